lbp_code_gen: RTL and testbench

- Downstream stage of the radius-R interpolation stage.
- Takes the eight interpolated circular samples S1..S8 (8.16 fixed point) plus the aligned centre pixel.
- Thresholds each sample against the centre and emits an 8-bit LBP code, or a rotation-invariant uniform (riu2) label.
- Passes the pixel-valid (done) and frame-end (progress_done) strobes through with matched latency and keeps a per-frame count of emitted codes for the histogram stage.

---
 rtl/lbp_pkg.sv | 22 ++
 rtl/lbp_riu2_map.sv | 42 ++++
 rtl/lbp_code_gen.sv | 126 ++++++++++++
 tb/tb_lbp_code_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared constants and helpers for the LBP code generator.
// Pixel/sample width defaults, riu2 non-uniform label, mode encodings.
package lbp_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int FRAC_W_DEF = 16;

    localparam logic [3:0] LBP_NONUNIFORM = 4'd9;

    localparam int MODE_RAW  = 0;
    localparam int MODE_RIU2 = 1;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/lbp_riu2_map.sv
// Stage 2 register: circular transition count U and popcount P of a code.
// Ports: clk, rst (async low), valid_i/code_i in; valid_o/code_o/label_o out.
module lbp_riu2_map
    import lbp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic [7:0] code_i,
    output logic       valid_o,
    output logic [7:0] code_o,
    output logic [3:0] label_o
);

    logic [3:0] u_c;
    logic [3:0] p_c;
    logic [3:0] u_q;
    logic [3:0] p_q;

    // Rotating right by one pairs each bit with its circular neighbour.
    always_comb begin
        u_c = popcnt8(code_i ^ {code_i[0], code_i[7:1]});
        p_c = popcnt8(code_i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o <= 1'b0;
            code_o  <= '0;
            u_q     <= '0;
            p_q     <= '0;
        end else begin
            valid_o <= valid_i;
            code_o  <= code_i;
            u_q     <= u_c;
            p_q     <= p_c;
        end
    end

    assign label_o = (u_q <= 4'd2) ? p_q : LBP_NONUNIFORM;

endmodule

// File: rtl/lbp_code_gen.sv
// Thresholds eight interpolated samples against the centre pixel and emits
// an LBP code or riu2 label (3-cycle latency) plus per-frame code counts.
// Ports: clk, rst (async low), done_i, progress_done_i, C_i, S1_i..S8_i in;
//        lbp_o, done_o, progress_done_o, pix_cnt_o, frame_pix_o out.
module lbp_code_gen
    import lbp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int MODE   = MODE_RAW,
    parameter int CNT_W  = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     done_i,
    input  logic                     progress_done_i,
    input  logic [DATA_W-1:0]        C_i,
    input  logic [DATA_W+FRAC_W-1:0] S1_i,
    input  logic [DATA_W+FRAC_W-1:0] S2_i,
    input  logic [DATA_W+FRAC_W-1:0] S3_i,
    input  logic [DATA_W+FRAC_W-1:0] S4_i,
    input  logic [DATA_W+FRAC_W-1:0] S5_i,
    input  logic [DATA_W+FRAC_W-1:0] S6_i,
    input  logic [DATA_W+FRAC_W-1:0] S7_i,
    input  logic [DATA_W+FRAC_W-1:0] S8_i,
    output logic [7:0]               lbp_o,
    output logic                     done_o,
    output logic                     progress_done_o,
    output logic [CNT_W-1:0]         pix_cnt_o,
    output logic [CNT_W-1:0]         frame_pix_o
);

    localparam int SW = DATA_W + FRAC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [7:0][SW-1:0] samp;
    logic [SW-1:0]      thr;
    logic [7:0]         code_c;

    logic [7:0] code1;
    logic       v1;
    logic       pd1;

    logic       v2;
    logic       pd2;
    logic [7:0] code2;
    logic [3:0] label2;

    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;

    assign samp = {S8_i, S7_i, S6_i, S5_i, S4_i, S3_i, S2_i, S1_i};
    assign thr  = {C_i, {FRAC_W{1'b0}}};

    // Any fractional excess over an equal integer part counts as >= centre.
    always_comb begin
        code_c = '0;
        for (int k = 0; k < 8; k++) begin
            code_c[k] = (samp[k] >= thr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code1 <= '0;
            v1    <= 1'b0;
            pd1   <= 1'b0;
        end else begin
            code1 <= code_c;
            v1    <= done_i;
            pd1   <= progress_done_i;
        end
    end

    lbp_riu2_map u_map (
        .clk     (clk),
        .rst     (rst),
        .valid_i (v1),
        .code_i  (code1),
        .valid_o (v2),
        .code_o  (code2),
        .label_o (label2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pd2 <= 1'b0;
        end else begin
            pd2 <= pd1;
        end
    end

    // A frame end restarts the count; the pixel arriving with it counts.
    always_comb begin
        cnt_base = progress_done_o ? '0 : pix_cnt_o;
        cnt_next = cnt_base;
        if (v2 && (cnt_base != CNT_MAX)) begin
            cnt_next = cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lbp_o           <= '0;
            done_o          <= 1'b0;
            progress_done_o <= 1'b0;
            pix_cnt_o       <= '0;
            frame_pix_o     <= '0;
        end else begin
            done_o          <= v2;
            progress_done_o <= pd2;
            pix_cnt_o       <= cnt_next;
            if (pd2) begin
                frame_pix_o <= cnt_next;
            end
            if (v2) begin
                if (MODE == MODE_RIU2) begin
                    lbp_o <= {4'b0000, label2};
                end else begin
                    lbp_o <= code2;
                end
            end
        end
    end

endmodule

// File: tb/tb_lbp_code_gen.sv
// Directed bench for lbp_code_gen: raw-mode and riu2-mode instances side by
// side on shared stimulus, with a narrow counter on the riu2 instance.
module tb_lbp_code_gen;

    logic               clk;
    logic               rst;
    logic               done_i;
    logic               progress_done_i;
    logic [7:0]         c_in;
    logic [7:0][23:0]   sv;

    logic [7:0]  lbp0;
    logic        done0;
    logic        pd0;
    logic [19:0] pix0;
    logic [19:0] fr0;

    logic [7:0]  lbp1;
    logic        done1;
    logic        pd1;
    logic [2:0]  pix1;
    logic [2:0]  fr1;

    int vectors;
    int errs;
    int npix;
    logic seen;

    lbp_code_gen #(.MODE(0), .CNT_W(20)) u0 (
        .clk(clk), .rst(rst), .done_i(done_i),
        .progress_done_i(progress_done_i), .C_i(c_in),
        .S1_i(sv[0]), .S2_i(sv[1]), .S3_i(sv[2]), .S4_i(sv[3]),
        .S5_i(sv[4]), .S6_i(sv[5]), .S7_i(sv[6]), .S8_i(sv[7]),
        .lbp_o(lbp0), .done_o(done0), .progress_done_o(pd0),
        .pix_cnt_o(pix0), .frame_pix_o(fr0)
    );

    lbp_code_gen #(.MODE(1), .CNT_W(3)) u1 (
        .clk(clk), .rst(rst), .done_i(done_i),
        .progress_done_i(progress_done_i), .C_i(c_in),
        .S1_i(sv[0]), .S2_i(sv[1]), .S3_i(sv[2]), .S4_i(sv[3]),
        .S5_i(sv[4]), .S6_i(sv[5]), .S7_i(sv[6]), .S8_i(sv[7]),
        .lbp_o(lbp1), .done_o(done1), .progress_done_o(pd1),
        .pix_cnt_o(pix1), .frame_pix_o(fr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat7(input int n);
        return (n > 7) ? 7 : n;
    endfunction

    task automatic set_all(input logic [23:0] v);
        for (int k = 0; k < 8; k++) sv[k] = v;
    endtask

    // Drive one pixel at a falling edge and check it three rising edges later.
    task automatic send(input string tag, input logic [7:0] e0,
                        input logic [7:0] e1);
        done_i = 1'b1;
        progress_done_i = 1'b0;
        @(negedge clk);
        done_i = 1'b0;
        @(negedge clk);
        chk({tag, "_early"}, {30'd0, done0, done1}, 32'd0);
        @(negedge clk);
        chk({tag, "_done"}, {30'd0, done0, done1}, 32'd3);
        chk({tag, "_raw"}, {24'd0, lbp0}, {24'd0, e0});
        chk({tag, "_riu2"}, {24'd0, lbp1}, {24'd0, e1});
        npix++;
    endtask

    // n back-to-back pixels, frame end on the last one.
    task automatic burst(input int n);
        int k;
        done_i = 1'b1;
        progress_done_i = (n == 1);
        set_all(24'h123456);
        c_in = 8'h20;
        for (int j = 1; j <= n + 3; j++) begin
            @(negedge clk);
            k = j - 3;
            if (k >= 0 && k < n) begin
                chk("burst_done", {30'd0, done0, done1}, 32'd3);
                chk("burst_pix0", {12'd0, pix0}, k + 1);
                chk("burst_pix1", {29'd0, pix1}, sat7(k + 1));
            end
            if (k == n - 1) begin
                chk("burst_pd", {30'd0, pd0, pd1}, 32'd3);
                chk("burst_frame0", {12'd0, fr0}, n);
                chk("burst_frame1", {29'd0, fr1}, sat7(n));
            end
            if (j == n + 3) begin
                chk("burst_idle", {30'd0, done0, pd0}, 32'd0);
                chk("burst_clr", {9'd0, pix0, pix1}, 32'd0);
            end
            done_i = (j < n);
            progress_done_i = (j == n - 1);
        end
    endtask

    initial begin
        vectors = 0;
        errs = 0;
        npix = 0;
        rst = 1'b0;
        done_i = 1'b1;
        progress_done_i = 1'b1;
        c_in = 8'($urandom);
        for (int k = 0; k < 8; k++) sv[k] = 24'($urandom);

        repeat (4) begin
            @(negedge clk);
            c_in = 8'($urandom);
            for (int k = 0; k < 8; k++) sv[k] = 24'($urandom);
        end
        chk("rst_strobes", {28'd0, done0, pd0, done1, pd1}, 32'd0);
        chk("rst_lbp", {16'd0, lbp0, lbp1}, 32'd0);
        chk("rst_cnt0", {12'd0, pix0}, 32'd0);
        chk("rst_frame0", {12'd0, fr0}, 32'd0);
        chk("rst_cnt1", {26'd0, pix1, fr1}, 32'd0);

        done_i = 1'b0;
        progress_done_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        c_in = 8'h64;
        set_all(24'h640000);
        send("eq", 8'hFF, 8'h08);

        set_all(24'h640001);
        sv[0] = 24'h63FFFF;
        send("frac", 8'hFE, 8'h07);

        set_all(24'h63FFFF);
        sv[0] = 24'h640000;
        sv[2] = 24'h640000;
        sv[4] = 24'h640000;
        sv[6] = 24'h640000;
        send("alt", 8'h55, 8'h09);

        set_all(24'h00FFFF);
        send("zero", 8'h00, 8'h00);

        c_in = 8'hFF;
        set_all(24'hFEFFFF);
        for (int k = 0; k < 4; k++) sv[k] = 24'hFF0000;
        send("half", 8'h0F, 8'h04);

        c_in = 8'h00;
        set_all(24'h000000);
        send("czero", 8'hFF, 8'h08);

        c_in = 8'h80;
        set_all(24'h7FFFFF);
        sv[0] = 24'h800000;
        sv[2] = 24'h800000;
        send("nonuni", 8'h05, 8'h09);

        @(negedge clk);
        chk("hold_raw", {24'd0, lbp0}, 32'h05);
        chk("hold_riu2", {24'd0, lbp1}, 32'h09);

        progress_done_i = 1'b1;
        @(negedge clk);
        progress_done_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("flush_pd", {30'd0, pd0, done0}, 32'd2);
        chk("flush_frame0", {12'd0, fr0}, npix);
        chk("flush_frame1", {29'd0, fr1}, sat7(npix));
        @(negedge clk);
        chk("flush_clr", {9'd0, pix0, pix1}, 32'd0);

        burst(5);
        burst(9);

        done_i = 1'b0;
        progress_done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        progress_done_i = 1'b0;
        @(negedge clk);
        chk("b2b_first", {29'd0, pd0, done0, 1'b0}, 32'd4);
        chk("b2b_frame_a", {12'd0, fr0}, 32'd0);
        @(negedge clk);
        chk("b2b_second", {30'd0, pd0, done0}, 32'd3);
        chk("b2b_frame_b", {12'd0, fr0}, 32'd1);
        chk("b2b_pix", {12'd0, pix0}, 32'd1);
        @(negedge clk);
        chk("b2b_clr", {12'd0, pix0}, 32'd0);

        done_i = 1'b1;
        progress_done_i = 1'b0;
        @(negedge clk);
        progress_done_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        done_i = 1'b0;
        progress_done_i = 1'b0;
        @(negedge clk);
        chk("mid_rst_frame", {12'd0, fr0}, 32'd0);
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | done0 | pd0 | done1 | pd1;
        end
        chk("mid_rst_quiet", {31'd0, seen}, 32'd0);
        chk("mid_rst_pix", {12'd0, pix0}, 32'd0);
        chk("mid_rst_fr", {12'd0, fr0}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
